// File: rtl/oram_backend_model_pkg.sv
// Shared backend command encoding and the responder's FSM state type.
package oram_backend_model_pkg;

  localparam int unsigned BECMDWidth = 2;

  typedef enum logic [BECMDWidth-1:0] {
    BECMD_Update  = 2'd0,
    BECMD_Append  = 2'd1,
    BECMD_Read    = 2'd2,
    BECMD_ReadRmv = 2'd3
  } becmd_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WRITE_DATA,
    ST_WAIT,
    ST_READ_OUT
  } state_t;

endpackage

// File: rtl/oram_model_serializer.sv
// Block register with a beat counter: deserializes write beats into a block
// and serializes a parallel-loaded block back out one beat at a time.
module oram_model_serializer #(
  parameter int unsigned ORAMB    = 512,
  parameter int unsigned FEDWidth = 512
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                load,
  input  logic [ORAMB-1:0]    load_block,
  input  logic                shift_in,
  input  logic [FEDWidth-1:0] beat_in,
  input  logic                shift_out,
  output logic [FEDWidth-1:0] beat_out,
  output logic                last,
  output logic [ORAMB-1:0]    merged_block
);

  localparam int unsigned NB = ORAMB / FEDWidth;
  localparam int unsigned CW = (NB > 1) ? $clog2(NB) : 1;

  logic [ORAMB-1:0] blk;
  logic [CW-1:0]    cnt;

  // merged_block already holds the incoming beat, so the final write beat
  // can be committed to storage in the same cycle it is accepted.
  always_comb begin
    beat_out     = blk[int'(cnt)*FEDWidth +: FEDWidth];
    last         = (32'(cnt) == NB - 1);
    merged_block = blk;
    merged_block[int'(cnt)*FEDWidth +: FEDWidth] = beat_in;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      blk <= '0;
      cnt <= '0;
    end else if (load) begin
      blk <= load_block;
      cnt <= '0;
    end else if (shift_in) begin
      blk <= merged_block;
      cnt <= last ? '0 : cnt + 1'b1;
    end else if (shift_out) begin
      cnt <= last ? '0 : cnt + 1'b1;
    end
  end

endmodule

// File: rtl/oram_backend_model.sv
// On-chip stand-in for the Path ORAM backend: stores written blocks and
// returns them (or an address-derived pattern) after a fixed latency.
module oram_backend_model
  import oram_backend_model_pkg::*;
#(
  parameter int unsigned ORAMU           = 32,
  parameter int unsigned ORAMB           = 512,
  parameter int unsigned FEDWidth        = 512,
  parameter int unsigned NumValidBlock   = 1024,
  parameter int unsigned ResponseLatency = 6
) (
  input  logic                  Clock,
  input  logic                  Reset,
  input  logic [BECMDWidth-1:0] Command,
  input  logic [ORAMU-1:0]      PAddr,
  input  logic                  CommandValid,
  output logic                  CommandReady,
  input  logic [FEDWidth-1:0]   DataIn,
  input  logic                  DataInValid,
  output logic                  DataInReady,
  output logic [FEDWidth-1:0]   ReturnData,
  output logic                  ReturnDataValid,
  input  logic                  ReturnDataReady,
  output logic [31:0]           AccessCount
);

  localparam int unsigned IW = $clog2(NumValidBlock);

  state_t                 state, state_next;
  becmd_t                 cmd;
  logic [ORAMU-1:0]       addr;
  logic [IW-1:0]          idx;
  logic [31:0]            lat_cnt;
  logic [NumValidBlock-1:0] valid;
  logic [ORAMB-1:0]       mem [NumValidBlock];

  logic                   accept_cmd, beat_wr, beat_rd, lat_done, commit, finish_rd;
  logic [ORAMB-1:0]       pattern, load_block, merged_block;
  logic [FEDWidth-1:0]    beat_out;
  logic                   last;

  assign idx = addr[IW-1:0];

  oram_model_serializer #(
    .ORAMB   (ORAMB),
    .FEDWidth(FEDWidth)
  ) u_serializer (
    .clk         (Clock),
    .reset       (Reset),
    .load        (lat_done),
    .load_block  (load_block),
    .shift_in    (beat_wr),
    .beat_in     (DataIn),
    .shift_out   (beat_rd),
    .beat_out    (beat_out),
    .last        (last),
    .merged_block(merged_block)
  );

  always_comb begin
    pattern = '0;
    for (int unsigned i = 0; i < ORAMB / ORAMU; i++) begin
      pattern[i*ORAMU +: ORAMU] = addr + ORAMU'(i);
    end
    load_block = valid[idx] ? mem[idx] : pattern;
  end

  always_comb begin
    CommandReady    = (state == ST_IDLE) && !Reset;
    DataInReady     = (state == ST_WRITE_DATA) && !Reset;
    ReturnDataValid = (state == ST_READ_OUT) && !Reset;
    ReturnData      = ReturnDataValid ? beat_out : '0;
    accept_cmd      = CommandValid && CommandReady;
    beat_wr         = DataInValid && DataInReady;
    beat_rd         = ReturnDataValid && ReturnDataReady;
    lat_done        = (state == ST_WAIT) && (lat_cnt == '0) && !Reset;
    commit          = beat_wr && last;
    finish_rd       = beat_rd && last;

    state_next = state;
    unique case (state)
      ST_IDLE: begin
        if (accept_cmd) begin
          unique case (becmd_t'(Command))
            BECMD_Read, BECMD_ReadRmv: state_next = ST_WAIT;
            default:                   state_next = ST_WRITE_DATA;
          endcase
        end
      end
      ST_WRITE_DATA: if (commit)    state_next = ST_IDLE;
      ST_WAIT:       if (lat_done)  state_next = ST_READ_OUT;
      ST_READ_OUT:   if (finish_rd) state_next = ST_IDLE;
      default:                      state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      state       <= ST_IDLE;
      cmd         <= BECMD_Update;
      addr        <= '0;
      lat_cnt     <= '0;
      valid       <= '0;
      AccessCount <= '0;
    end else begin
      state <= state_next;
      if (accept_cmd) begin
        cmd     <= becmd_t'(Command);
        addr    <= PAddr;
        lat_cnt <= 32'(ResponseLatency - 1);
      end else if ((state == ST_WAIT) && (lat_cnt != '0)) begin
        lat_cnt <= lat_cnt - 32'd1;
      end
      if (commit) valid[idx] <= 1'b1;
      if (lat_done && (cmd == BECMD_ReadRmv)) valid[idx] <= 1'b0;
      if (commit || finish_rd) AccessCount <= AccessCount + 32'd1;
    end
  end

  // Storage is deliberately left out of reset; only the valid bits clear.
  always_ff @(posedge Clock) begin
    if (commit) mem[idx] <= merged_block;
  end

endmodule

// File: tb/tb_oram_backend_model.sv
// Randomized scoreboard bench for oram_backend_model with a 2-beat block.
module tb_oram_backend_model;
  import oram_backend_model_pkg::*;

  localparam int unsigned ORAMU = 32;
  localparam int unsigned ORAMB = 1024;
  localparam int unsigned FW    = 512;
  localparam int unsigned NVB   = 1024;
  localparam int unsigned LAT   = 6;
  localparam int unsigned NB    = ORAMB / FW;
  localparam int unsigned NCH   = ORAMB / ORAMU;

  logic                  Clock = 1'b0;
  logic                  Reset = 1'b1;
  logic [BECMDWidth-1:0] Command = '0;
  logic [ORAMU-1:0]      PAddr = '0;
  logic                  CommandValid = 1'b0;
  logic                  CommandReady;
  logic [FW-1:0]         DataIn = '0;
  logic                  DataInValid = 1'b0;
  logic                  DataInReady;
  logic [FW-1:0]         ReturnData;
  logic                  ReturnDataValid;
  logic                  ReturnDataReady = 1'b1;
  logic [31:0]           AccessCount;

  oram_backend_model #(
    .ORAMU(ORAMU), .ORAMB(ORAMB), .FEDWidth(FW),
    .NumValidBlock(NVB), .ResponseLatency(LAT)
  ) dut (
    .Clock(Clock), .Reset(Reset), .Command(Command), .PAddr(PAddr),
    .CommandValid(CommandValid), .CommandReady(CommandReady),
    .DataIn(DataIn), .DataInValid(DataInValid), .DataInReady(DataInReady),
    .ReturnData(ReturnData), .ReturnDataValid(ReturnDataValid),
    .ReturnDataReady(ReturnDataReady), .AccessCount(AccessCount)
  );

  always #5 Clock = ~Clock;

  int cyc = 0;
  always @(posedge Clock) cyc <= cyc + 1;

  int tests = 0;
  int fails = 0;

  // Reference model: plain arrays of blocks, valid flags and a counter.
  logic [ORAMB-1:0] ref_mem [NVB];
  bit               ref_vld [NVB];
  int unsigned      ref_count = 0;

  logic [FW-1:0] exp_q[$];
  int            lat_q[$];

  int rdy_mode = 0;
  always @(posedge Clock) begin
    #1;
    case (rdy_mode)
      0:       ReturnDataReady = 1'b1;
      1:       ReturnDataReady = ~ReturnDataReady;
      default: ReturnDataReady = 1'($urandom % 2);
    endcase
  end

  function automatic logic [ORAMB-1:0] pattern_of(input logic [31:0] a);
    logic [ORAMB-1:0] p;
    for (int i = 0; i < NCH; i++) p[i*32 +: 32] = a + 32'(i);
    return p;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: compares every valid return cycle against the scoreboard head.
  bit in_resp = 1'b0;
  int beat_i  = 0;
  always @(negedge Clock) begin
    if (!Reset && ReturnDataValid) begin
      if (!in_resp) begin
        in_resp = 1'b1;
        tests++;
        if (lat_q.size() == 0) begin
          fails++;
          $display("FAIL first_beat_latency: unexpected response at cycle %0d", cyc);
        end else begin
          int e;
          e = lat_q.pop_front();
          if (cyc != e) begin
            fails++;
            $display("FAIL first_beat_latency: got cycle %0d expected %0d", cyc, e);
          end
        end
      end
      tests++;
      if (exp_q.size() == 0) begin
        fails++;
        $display("FAIL return_data: unexpected beat %h", ReturnData);
      end else if (ReturnData !== exp_q[0]) begin
        fails++;
        $display("FAIL return_data: got %h expected %h", ReturnData, exp_q[0]);
      end
      if (ReturnDataReady) begin
        if (exp_q.size() != 0) void'(exp_q.pop_front());
        beat_i++;
        if (beat_i == NB) begin
          beat_i  = 0;
          in_resp = 1'b0;
        end
      end
    end
  end

  task automatic send_cmd(input becmd_t c, input logic [31:0] a, output bit ok, output int t);
    int n = 0;
    Command = c; PAddr = a; CommandValid = 1'b1;
    @(negedge Clock);
    while (!CommandReady && n < 200) begin n++; @(negedge Clock); end
    ok = CommandReady;
    t  = cyc;
    if (!ok) chk("command_accept_timeout", 64'(CommandReady), 64'd1);
    @(posedge Clock); #1;
    CommandValid = 1'b0;
  endtask

  task automatic do_write(input becmd_t c, input logic [31:0] a, input logic [ORAMB-1:0] blk,
                          input int nbeats);
    bit ok;
    int t;
    send_cmd(c, a, ok, t);
    if (!ok) return;
    for (int k = 0; k < nbeats; k++) begin
      int n = 0;
      repeat ($urandom % 3) begin @(posedge Clock); #1; end
      DataIn = blk[k*FW +: FW];
      DataInValid = 1'b1;
      @(negedge Clock);
      while (!DataInReady && n < 200) begin n++; @(negedge Clock); end
      if (!DataInReady) chk("data_in_ready_timeout", 64'(DataInReady), 64'd1);
      @(posedge Clock); #1;
      DataInValid = 1'b0;
    end
    if (nbeats == NB) begin
      ref_mem[a % NVB] = blk;
      ref_vld[a % NVB] = 1'b1;
      ref_count++;
    end
  endtask

  task automatic do_read(input becmd_t c, input logic [31:0] a);
    bit ok;
    int t;
    logic [ORAMB-1:0] blk;
    blk = ref_vld[a % NVB] ? ref_mem[a % NVB] : pattern_of(a);
    for (int k = 0; k < NB; k++) exp_q.push_back(blk[k*FW +: FW]);
    send_cmd(c, a, ok, t);
    if (!ok) return;
    lat_q.push_back(t + LAT + 1);
    if (c == BECMD_ReadRmv) ref_vld[a % NVB] = 1'b0;
    ref_count++;
    // Stray write data during the latency window must be ignored.
    DataIn = {16{$urandom}};
    DataInValid = 1'b1;
    repeat (3) begin @(posedge Clock); #1; end
    DataInValid = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    @(negedge Clock);
    while (!CommandReady && n < 300) begin n++; @(negedge Clock); end
    if (!CommandReady) chk("idle_timeout", 64'(CommandReady), 64'd1);
    @(posedge Clock); #1;
  endtask

  task automatic check_count(input string name);
    wait_idle();
    chk(name, 64'(AccessCount), 64'(ref_count));
  endtask

  task automatic do_reset();
    Reset = 1'b1; CommandValid = 1'b0; DataInValid = 1'b0;
    @(negedge Clock);
    chk("command_ready_in_reset", 64'(CommandReady), 64'd0);
    @(posedge Clock); @(negedge Clock);
    chk("data_in_ready_reset", 64'(DataInReady), 64'd0);
    chk("return_valid_reset", 64'(ReturnDataValid), 64'd0);
    chk("return_data_zero_reset", 64'(ReturnData == '0), 64'd1);
    chk("access_count_reset", 64'(AccessCount), 64'd0);
    @(posedge Clock); #1;
    Reset = 1'b0;
    for (int i = 0; i < NVB; i++) ref_vld[i] = 1'b0;
    ref_count = 0;
    @(negedge Clock);
    chk("command_ready_after_reset", 64'(CommandReady), 64'd1);
    @(posedge Clock); #1;
  endtask

  function automatic logic [ORAMB-1:0] rand_block();
    logic [ORAMB-1:0] b;
    for (int i = 0; i < NCH; i++) b[i*32 +: 32] = $urandom;
    return b;
  endfunction

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [ORAMB-1:0] blk;
    logic [31:0] a;
    becmd_t c;

    do_reset();

    do_read(BECMD_Read, 32'd5);
    check_count("count_after_pattern_read");

    do_write(BECMD_Update, 32'd5, {(ORAMB/8){8'hA5}}, NB);
    do_read(BECMD_Read, 32'd5);
    check_count("count_after_update_read");

    do_read(BECMD_ReadRmv, 32'd5);
    do_read(BECMD_Read, 32'd5);
    check_count("count_after_readrmv");

    rdy_mode = 1;
    do_write(BECMD_Append, 32'd7, {{(FW/8){8'hB1}}, {(FW/8){8'hB0}}}, NB);
    do_read(BECMD_Read, 32'd7);
    check_count("count_after_stalled_read");
    rdy_mode = 0;

    do_write(BECMD_Update, 32'd1029, rand_block(), NB);
    do_read(BECMD_Read, 32'd5);
    do_read(BECMD_ReadRmv, 32'd1029);
    do_read(BECMD_Read, 32'd1029);
    do_read(BECMD_Read, 32'hFFFF_FFFF);
    check_count("count_after_alias");

    do_write(BECMD_Update, 32'd9, {{(FW/8){8'hC1}}, {(FW/8){8'hC0}}}, NB);
    do_write(BECMD_Update, 32'd9, rand_block(), 1);
    do_reset();
    do_read(BECMD_Read, 32'd9);
    check_count("count_after_midwrite_reset");

    for (int n = 0; n < 150; n++) begin
      case ($urandom % 4)
        0:       a = 32'($urandom % 8);
        1:       a = 32'($urandom % 8) + 32'(1024 * $urandom_range(1, 3));
        2:       a = 32'hFFFF_FFF0 + 32'($urandom % 16);
        default: a = $urandom;
      endcase
      c = becmd_t'($urandom % 4);
      rdy_mode = int'($urandom % 3);
      if (c == BECMD_Update || c == BECMD_Append) do_write(c, a, rand_block(), NB);
      else do_read(c, a);
      if (n % 25 == 24) check_count("count_random");
    end
    rdy_mode = 0;
    check_count("count_final");
    chk("scoreboard_drained", 64'(exp_q.size() + lat_q.size()), 64'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
